issue_pipe_sched: RTL and testbench

//  Issue scheduler between decode and the parallel execute pipes. Holds one

---
 rtl/issue_pipe_sched.sv | 126 ++++++++++++
 tb/tb_issue_pipe_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_pipe_sched.sv
// Issue scheduler: a single holding stage between decode and the execute pipes.
// The held instruction goes to exactly one capable, ready pipe. The pipe is
// picked round-robin from a pointer shared by all op classes. An op that no
// pipe can run is dropped with a one-cycle unsup pulse. Cycles spent holding
// a runnable op without issuing it are counted in a saturating stall counter.
module issue_pipe_sched #(
   parameter int p_num_pipes    = 3,
   parameter int p_seq_num_bits = 5,
   parameter int p_num_ops      = 7,
   parameter logic [p_num_pipes-1:0][p_num_ops-1:0] p_pipe_subsets = '1,
   localparam int p_idx_bits = (p_num_pipes < 2) ? 1 : $clog2(p_num_pipes)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_val,
   output logic                      in_rdy,
   input  logic [p_num_ops-1:0]      in_op_vec,
   input  logic [p_seq_num_bits-1:0] in_seq_num,
   input  logic [p_num_pipes-1:0]    pipe_rdy,
   output logic [p_num_pipes-1:0]    pipe_val,
   output logic [p_seq_num_bits-1:0] out_seq_num,
   output logic [p_idx_bits-1:0]     out_pipe_idx,
   output logic                      unsup,
   output logic [15:0]               stall_cnt
);

   // One extra bit lets rr_ptr + offset run past the last pipe
   // before it is folded back into range.
   localparam logic [p_idx_bits:0]   num_pipes_ext = (p_idx_bits+1)'(p_num_pipes);
   localparam logic [p_idx_bits-1:0] last_idx      = p_idx_bits'(p_num_pipes - 1);

   logic                      hold_val;
   logic [p_num_ops-1:0]      hold_op;
   logic [p_seq_num_bits-1:0] hold_seq;
   logic [p_idx_bits-1:0]     rr_ptr;

   logic [p_num_pipes-1:0]    cap;
   logic [p_num_pipes-1:0]    elig;
   logic                      cap_any;
   logic                      grant_found;
   logic [p_idx_bits-1:0]     grant_idx;
   logic [p_idx_bits:0]       scan_idx;
   logic                      issue;
   logic                      accept;
   logic                      stall_inc;
   logic [p_idx_bits-1:0]     rr_ptr_next;

   // Which pipes can execute the held op class
   always_comb begin
      cap = '0;
      for (int j = 0; j < p_num_pipes; j++) begin
         cap[j] = |(p_pipe_subsets[j] & hold_op);
      end
   end

   assign elig    = {p_num_pipes{hold_val}} & cap & pipe_rdy;
   assign cap_any = |cap;

   // Round-robin scan starting at rr_ptr; first eligible pipe wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < p_num_pipes; k++) begin
         scan_idx = {1'b0, rr_ptr} + (p_idx_bits+1)'(k);
         if (scan_idx >= num_pipes_ext) begin
            scan_idx = scan_idx - num_pipes_ext;
         end
         if (!grant_found && elig[scan_idx[p_idx_bits-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[p_idx_bits-1:0];
         end
      end
   end

   // One-hot issue strobe toward the granted pipe
   always_comb begin
      pipe_val = '0;
      if (grant_found) begin
         pipe_val[grant_idx] = 1'b1;
      end
   end

   assign issue        = grant_found;
   assign unsup        = hold_val & ~cap_any;
   assign in_rdy       = ~hold_val | issue | unsup;
   assign accept       = in_val & in_rdy;
   assign stall_inc    = hold_val & cap_any & ~issue;
   assign out_seq_num  = hold_seq;
   assign out_pipe_idx = grant_idx;
   assign rr_ptr_next  = (grant_idx == last_idx) ? '0 : grant_idx + p_idx_bits'(1);

   // Holding register: refill on accept, otherwise empty once issued or dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_val <= 1'b0;
         hold_op  <= '0;
         hold_seq <= '0;
      end else if (accept) begin
         hold_val <= 1'b1;
         hold_op  <= in_op_vec;
         hold_seq <= in_seq_num;
      end else if (issue || unsup) begin
         hold_val <= 1'b0;
      end
   end

   // Pointer moves just past the granted pipe; it holds when nothing issues
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (issue) begin
         rr_ptr <= rr_ptr_next;
      end
   end

   // Saturating count of cycles where a runnable op sat without issuing
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_issue_pipe_sched.sv
// Bench for issue_pipe_sched: three 3-pipe instances with different capability
// sets, checked every cycle against a queue-free behavioural model plus
// hand-computed literal expectations for the directed scenarios.
module tb_issue_pipe_sched;

   localparam logic [6:0] op_add = 7'h01;
   localparam logic [6:0] op_mul = 7'h02;
   localparam logic [6:0] op_all = 7'h7F;
   // instance 0: all pipes run everything
   // instance 1: pipe0 ALL, pipe1 ALL, pipe2 ADD only
   // instance 2: every pipe MUL only
   localparam logic [2:0][2:0][6:0] subs = {{op_mul, op_mul, op_mul},
                                            {op_add, op_all, op_all},
                                            {op_all, op_all, op_all}};

   logic            clk;
   logic [2:0]      rst_v;
   logic [2:0]      in_val_v;
   logic [2:0]      in_rdy_v;
   logic [2:0][6:0] op_v;
   logic [2:0][4:0] seq_v;
   logic [2:0][2:0] prdy_v;
   logic [2:0][2:0] pval_v;
   logic [2:0][4:0] oseq_v;
   logic [2:0][1:0] oidx_v;
   logic [2:0]      unsup_v;
   logic [2:0][15:0] stall_v;

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      issue_pipe_sched #(
         .p_num_pipes(3),
         .p_seq_num_bits(5),
         .p_num_ops(7),
         .p_pipe_subsets(subs[g])
      ) u_dut (
         .clk(clk),
         .rst(rst_v[g]),
         .in_val(in_val_v[g]),
         .in_rdy(in_rdy_v[g]),
         .in_op_vec(op_v[g]),
         .in_seq_num(seq_v[g]),
         .pipe_rdy(prdy_v[g]),
         .pipe_val(pval_v[g]),
         .out_seq_num(oseq_v[g]),
         .out_pipe_idx(oidx_v[g]),
         .unsup(unsup_v[g]),
         .stall_cnt(stall_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model, compared on every falling edge
   initial begin
      int m_val [3];
      int m_ptr [3];
      int m_stall [3];
      logic [6:0] m_op [3];
      logic [4:0] m_seq [3];
      int grant, j;
      bit cap_any, ex_unsup, ex_rdy;
      logic [2:0] ex_pval;
      for (int i = 0; i < 3; i++) begin
         m_val[i] = 0; m_ptr[i] = 0; m_stall[i] = 0; m_op[i] = '0; m_seq[i] = '0;
      end
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            grant = -1;
            cap_any = 0;
            if (m_val[i] != 0) begin
               for (int k = 0; k < 3; k++) begin
                  j = (m_ptr[i] + k) % 3;
                  if ((subs[i][j] & m_op[i]) != 7'h00) begin
                     cap_any = 1;
                     if (prdy_v[i][j] && grant < 0) grant = j;
                  end
               end
            end
            ex_unsup = (m_val[i] != 0) && !cap_any;
            ex_pval  = (grant >= 0) ? 3'(1 << grant) : 3'b000;
            ex_rdy   = (m_val[i] == 0) || (grant >= 0) || ex_unsup;
            chk($sformatf("u%0d_pipe_val", i), 32'(pval_v[i]), 32'(ex_pval));
            chk($sformatf("u%0d_unsup", i), 32'(unsup_v[i]), 32'(ex_unsup));
            chk($sformatf("u%0d_in_rdy", i), 32'(in_rdy_v[i]), 32'(ex_rdy));
            chk($sformatf("u%0d_stall_cnt", i), 32'(stall_v[i]), 32'(m_stall[i]));
            if (grant >= 0) begin
               chk($sformatf("u%0d_out_seq", i), 32'(oseq_v[i]), 32'(m_seq[i]));
               chk($sformatf("u%0d_out_idx", i), 32'(oidx_v[i]), 32'(grant));
            end
            if (rst_v[i]) begin
               m_val[i] = 0; m_ptr[i] = 0; m_stall[i] = 0;
            end else begin
               if ((m_val[i] != 0) && cap_any && grant < 0 && m_stall[i] < 65535)
                  m_stall[i]++;
               if (grant >= 0) m_ptr[i] = (grant + 1) % 3;
               if (in_val_v[i] && ex_rdy) begin
                  m_val[i] = 1; m_op[i] = op_v[i]; m_seq[i] = seq_v[i];
               end else if (grant >= 0 || ex_unsup) begin
                  m_val[i] = 0;
               end
            end
         end
      end
   end

   // Directed stimulus with literal expectations
   initial begin
      logic [2:0] t1_exp [6];
      t1_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst_v    = '1;
      in_val_v = '0;
      op_v     = '0;
      seq_v    = '0;
      prdy_v   = '1;
      repeat (2) @(posedge clk);
      #1;
      rst_v = '0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_in_rdy", 32'(in_rdy_v[i]), 32'd1);
         chk("reset_pipe_val", 32'(pval_v[i]), 32'd0);
         chk("reset_unsup", 32'(unsup_v[i]), 32'd0);
         chk("reset_stall", 32'(stall_v[i]), 32'd0);
      end
      cyc();

      // six back-to-back ADDs rotate over the pipes
      op_v[0] = op_add;
      for (int k = 0; k < 7; k++) begin
         in_val_v[0] = (k < 6);
         seq_v[0]    = 5'(k);
         @(negedge clk);
         chk("t1_in_rdy", 32'(in_rdy_v[0]), 32'd1);
         if (k > 0) begin
            chk("t1_pipe_val", 32'(pval_v[0]), 32'(t1_exp[k-1]));
            chk("t1_out_seq", 32'(oseq_v[0]), 32'(k - 1));
         end
         cyc();
      end
      in_val_v[0] = 1'b0;

      // pointer wrap: rr_ptr=1 with only pipe0 ready
      in_val_v[0] = 1'b1; seq_v[0] = 5'd10;
      cyc();
      in_val_v[0] = 1'b0;
      @(negedge clk);
      chk("t4_first", 32'(pval_v[0]), 32'b001);
      cyc();
      in_val_v[0] = 1'b1; seq_v[0] = 5'd11; prdy_v[0] = 3'b001;
      cyc();
      in_val_v[0] = 1'b0;
      @(negedge clk);
      chk("t4_wrap", 32'(pval_v[0]), 32'b001);
      cyc();
      prdy_v[0] = 3'b111; in_val_v[0] = 1'b1; seq_v[0] = 5'd12;
      cyc();
      in_val_v[0] = 1'b0;
      @(negedge clk);
      chk("t4_after_wrap", 32'(pval_v[0]), 32'b010);
      chk("t4_after_idx", 32'(oidx_v[0]), 32'd1);
      cyc();

      // long stall saturates the counter
      in_val_v[0] = 1'b1; seq_v[0] = 5'd13; prdy_v[0] = 3'b000;
      cyc();
      in_val_v[0] = 1'b0;
      repeat (65540) cyc();
      @(negedge clk);
      chk("t5_stall_sat", 32'(stall_v[0]), 32'h0000FFFF);
      cyc();
      prdy_v[0] = 3'b111;
      @(negedge clk);
      chk("t5_release", 32'(pval_v[0]), 32'b100);
      chk("t5_stall_hold", 32'(stall_v[0]), 32'h0000FFFF);
      cyc();

      // MUL skips busy pipe0, then stalls while only the ADD-only pipe is ready
      op_v[1] = op_mul; in_val_v[1] = 1'b1; seq_v[1] = 5'd3; prdy_v[1] = 3'b110;
      cyc();
      in_val_v[1] = 1'b0;
      @(negedge clk);
      chk("t2_pipe1", 32'(pval_v[1]), 32'b010);
      chk("t2_seq", 32'(oseq_v[1]), 32'd3);
      chk("t2_no_stall", 32'(stall_v[1]), 32'd0);
      cyc();
      in_val_v[1] = 1'b1; seq_v[1] = 5'd4; prdy_v[1] = 3'b100;
      cyc();
      in_val_v[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_stalled", 32'(pval_v[1]), 32'b000);
         cyc();
      end
      prdy_v[1] = 3'b111;
      @(negedge clk);
      chk("t2_stall4", 32'(stall_v[1]), 32'd4);
      chk("t2_release", 32'(pval_v[1]), 32'b001);
      cyc();

      // reset while an entry is held
      in_val_v[1] = 1'b1; seq_v[1] = 5'd5; prdy_v[1] = 3'b000;
      cyc();
      in_val_v[1] = 1'b0; rst_v[1] = 1'b1;
      @(negedge clk);
      chk("t6_held", 32'(pval_v[1]), 32'b000);
      cyc();
      rst_v[1] = 1'b0; prdy_v[1] = 3'b111;
      @(negedge clk);
      chk("t6_pipe_val", 32'(pval_v[1]), 32'b000);
      chk("t6_in_rdy", 32'(in_rdy_v[1]), 32'd1);
      chk("t6_stall", 32'(stall_v[1]), 32'd0);
      cyc();
      op_v[1] = op_add; in_val_v[1] = 1'b1; seq_v[1] = 5'd6;
      cyc();
      in_val_v[1] = 1'b0;
      @(negedge clk);
      chk("t6_ptr_zero", 32'(pval_v[1]), 32'b001);
      cyc();

      // unsupported ADD is dropped while the next op is accepted
      op_v[2] = op_add; in_val_v[2] = 1'b1; seq_v[2] = 5'd7;
      cyc();
      op_v[2] = op_mul; seq_v[2] = 5'd8;
      @(negedge clk);
      chk("t3_unsup", 32'(unsup_v[2]), 32'd1);
      chk("t3_no_issue", 32'(pval_v[2]), 32'b000);
      chk("t3_in_rdy", 32'(in_rdy_v[2]), 32'd1);
      cyc();
      in_val_v[2] = 1'b0;
      @(negedge clk);
      chk("t3_unsup_pulse", 32'(unsup_v[2]), 32'd0);
      chk("t3_next_issue", 32'(pval_v[2]), 32'b001);
      chk("t3_next_seq", 32'(oseq_v[2]), 32'd8);
      chk("t3_stall", 32'(stall_v[2]), 32'd0);
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
